// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side master for a 16-deep FIFO.
// It drains the FIFO and re-emits the words as bursts on a valid/ready stream.
// A full burst starts on the FIFO threshold flag. A partial burst is flushed on an
// explicit flush pulse or after an idle timeout.
// Optional feature macro: FIFO_RD_STATS_EN adds the 16-bit saturating stat_bursts counter.
module fifo_burst_reader #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  input  logic              fifo_thr,
  output logic              fifo_rd,
  input  logic              flush,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [15:0]       stat_bursts
`endif
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN) + 1;
  localparam int unsigned TMO_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FULL = 2'd1,
    ST_PART = 2'd2
  } state_e;

  state_e            state_q,    state_d;
  logic [CNT_W-1:0]  popped_q,   popped_d;
  logic [CNT_W-1:0]  index_q,    index_d;
  logic [TMO_W-1:0]  tmo_q,      tmo_d;
  logic              hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0] hold_q,     hold_d;
  logic              m_valid_q,  m_valid_d;
  logic [DATA_W-1:0] m_data_q,   m_data_d;
  logic              m_last_q,   m_last_d;

  logic              in_burst_c;
  logic              move_c;
  logic              pop_c;
  logic              last_c;

  // Handshake decode: hold->output move, FIFO pop and end-of-burst marking
  always_comb begin
    in_burst_c = (state_q == ST_FULL) || (state_q == ST_PART);
    move_c     = hold_vld_q && (!m_valid_q || m_ready);
    pop_c      = !rst && in_burst_c && !fifo_empty &&
                 (popped_q < CNT_W'(BURST_LEN)) &&
                 (!hold_vld_q || move_c);
    // A partial burst ends when the FIFO has run dry and nothing new is entering hold
    last_c     = (index_q == CNT_W'(BURST_LEN - 1)) ||
                 ((state_q == ST_PART) && fifo_empty && !pop_c);
  end

  // Burst control: next state, idle timeout and per-burst pop/move counters
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    popped_d = popped_q;
    index_d  = index_q;
    case (state_q)
      ST_IDLE: begin
        popped_d = '0;
        index_d  = '0;
        if (fifo_thr) begin
          state_d = ST_FULL;
          tmo_d   = '0;
        end else if (flush && !fifo_empty) begin
          state_d = ST_PART;
          tmo_d   = '0;
        end else if (fifo_empty) begin
          tmo_d   = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = ST_PART;
          tmo_d   = '0;
        end else begin
          tmo_d   = tmo_q + TMO_W'(1);
        end
      end
      ST_FULL, ST_PART: begin
        tmo_d = '0;
        if (pop_c) begin
          popped_d = popped_q + CNT_W'(1);
        end
        if (move_c) begin
          index_d = index_q + CNT_W'(1);
        end
        if (move_c && last_c) begin
          state_d  = ST_IDLE;
          popped_d = '0;
          index_d  = '0;
        end else if ((state_q == ST_PART) && !hold_vld_q && fifo_empty &&
                     (popped_q == '0)) begin
          // Nothing was ever available for this partial burst: abandon it
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tmo_d    = '0;
        popped_d = '0;
        index_d  = '0;
      end
    endcase
  end

  // Two-stage datapath: FIFO head -> hold register -> output register
  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
    if (move_c) begin
      m_valid_d  = 1'b1;
      m_data_d   = hold_q;
      m_last_d   = last_c;
      hold_vld_d = 1'b0;
    end
    if (pop_c) begin
      hold_vld_d = 1'b1;
      hold_d     = fifo_data;
    end
  end

  // State and datapath registers with synchronous reset; in-flight words are discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      popped_q   <= '0;
      index_q    <= '0;
      tmo_q      <= '0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      popped_q   <= popped_d;
      index_q    <= index_d;
      tmo_q      <= tmo_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
    end
  end

  assign fifo_rd = pop_c;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q != ST_IDLE) || hold_vld_q || m_valid_q;

`ifdef FIFO_RD_STATS_EN
  logic [15:0] stat_q;

  // Completed-burst counter, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= '0;
    end else if (m_valid_q && m_ready && m_last_q && (stat_q != 16'hFFFF)) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign stat_bursts = stat_q;
`endif

endmodule
